// File: rtl/rr_trigger_arbiter.sv
// Round-robin arbiter that pops one upstream trigger counter per cycle and
// registers the winner into a one-entry valid/ready output stage.
module rr_trigger_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] req_pop,
  output logic                 out_valid,
  output logic [NUM_PORTS-1:0] out_onehot,
  output logic [IDX_W-1:0]     out_idx,
  input  logic                 out_ready
);

  // Highest legal index; also the reset value of last_q so port 0 wins first.
  localparam logic [IDX_W-1:0] LastMax   = IDX_W'(NUM_PORTS - 1);
  localparam logic [IDX_W:0]   NumPortsW = (IDX_W + 1)'(NUM_PORTS);

  logic [IDX_W-1:0]     last_q, last_d;
  logic                 out_valid_q, out_valid_d;
  logic [NUM_PORTS-1:0] out_onehot_q, out_onehot_d;
  logic [IDX_W-1:0]     out_idx_q, out_idx_d;

  logic [IDX_W-1:0]       start_idx;
  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [2*NUM_PORTS-1:0] req_rot;
  logic [IDX_W-1:0]       offset;
  logic [IDX_W:0]         idx_sum;
  logic [IDX_W-1:0]       grant_idx;
  logic [NUM_PORTS-1:0]   grant_oh;
  logic                   can_load;
  logic                   fire;

  // Priority search: rotate requests so the port after last_q sits at bit 0,
  // find the first set bit, then map the offset back modulo NUM_PORTS.
  always_comb begin
    start_idx = (last_q == LastMax) ? '0 : last_q + 1'b1;
    req_dbl   = {req_valid, req_valid};
    req_rot   = req_dbl >> start_idx;
    offset    = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = IDX_W'(i);
      end
    end
    // start_idx + offset never exceeds 2*NUM_PORTS-2, so one subtract wraps it.
    idx_sum = {1'b0, start_idx} + {1'b0, offset};
    if (idx_sum >= NumPortsW) begin
      idx_sum = idx_sum - NumPortsW;
    end
    grant_idx = idx_sum[IDX_W-1:0];
    grant_oh  = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      grant_oh[i] = (grant_idx == IDX_W'(i));
    end
  end

  // Handshake: a new grant may load whenever the output stage is empty or
  // being drained this cycle; reset suppresses any upstream pop.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    fire     = can_load && (|req_valid) && !rst;
    req_pop  = fire ? grant_oh : '0;
  end

  // Next-state for the rotation pointer and the output stage.
  always_comb begin
    last_d       = last_q;
    out_valid_d  = out_valid_q;
    out_onehot_d = out_onehot_q;
    out_idx_d    = out_idx_q;
    if (fire) begin
      last_d       = grant_idx;
      out_valid_d  = 1'b1;
      out_onehot_d = grant_oh;
      out_idx_d    = grant_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a held grant is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= LastMax;
      out_valid_q  <= 1'b0;
      out_onehot_q <= '0;
      out_idx_q    <= '0;
    end else begin
      last_q       <= last_d;
      out_valid_q  <= out_valid_d;
      out_onehot_q <= out_onehot_d;
      out_idx_q    <= out_idx_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign out_idx    = out_idx_q;

endmodule

// File: tb/tb_rr_trigger_arbiter.sv
// Directed plus random bench for rr_trigger_arbiter, running a 4-port and a
// 3-port instance in lockstep against a behavioural round-robin model.
module tb_rr_trigger_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic       out_ready;

  logic [3:0] pop4;
  logic       ov4;
  logic [3:0] oh4;
  logic [1:0] idx4;

  logic [2:0] pop3;
  logic       ov3;
  logic [2:0] oh3;
  logic [1:0] idx3;

  int checks = 0;
  int errors = 0;

  // Model state: [0] is the 4-port instance, [1] the 3-port instance.
  logic m_valid [2];
  int   m_last  [2];
  int   q4[$];
  int   q3[$];

  rr_trigger_arbiter #(.NUM_PORTS(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_pop    (pop4),
    .out_valid  (ov4),
    .out_onehot (oh4),
    .out_idx    (idx4),
    .out_ready  (out_ready)
  );

  rr_trigger_arbiter #(.NUM_PORTS(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[2:0]),
    .req_pop    (pop3),
    .out_valid  (ov3),
    .out_onehot (oh3),
    .out_idx    (idx3),
    .out_ready  (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference search: first requesting port scanning upward from last+1.
  function automatic int search(input int n, input int last, input logic [3:0] rv);
    for (int off = 1; off <= n; off++) begin
      int c;
      c = (last + off) % n;
      if (rv[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check combinational pop and the held output stage,
  // advance the model, then check registered outputs after the edge.
  task automatic step(input logic [3:0] rv, input logic rdy, input logic r);
    int          g    [2];
    logic        fire [2];
    logic [31:0] exp_pop [2];
    rst       = r;
    req_valid = rv;
    out_ready = rdy;
    #1;
    for (int k = 0; k < 2; k++) begin
      int n;
      n          = (k == 0) ? 4 : 3;
      g[k]       = search(n, m_last[k], rv);
      fire[k]    = (!m_valid[k] || rdy) && (g[k] >= 0) && !r;
      exp_pop[k] = fire[k] ? (32'd1 << g[k]) : 32'd0;
    end
    chk("pop4", {28'd0, pop4}, exp_pop[0]);
    chk("pop3", {29'd0, pop3}, exp_pop[1]);
    if (m_valid[0]) begin
      chk("idx4", {30'd0, idx4}, q4[0]);
      chk("onehot4", {28'd0, oh4}, 32'd1 << q4[0]);
    end
    if (m_valid[1]) begin
      chk("idx3", {30'd0, idx3}, q3[0]);
      chk("onehot3", {29'd0, oh3}, 32'd1 << q3[0]);
    end
    // Accepted entries leave the scoreboard before any new grant is pushed.
    if (m_valid[0] && rdy && q4.size() > 0) void'(q4.pop_front());
    if (m_valid[1] && rdy && q3.size() > 0) void'(q3.pop_front());
    if (r) begin
      q4.delete();
      q3.delete();
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
      m_last[0]  = 3;
      m_last[1]  = 2;
    end else begin
      if (fire[0]) begin
        q4.push_back(g[0]);
        m_valid[0] = 1'b1;
        m_last[0]  = g[0];
      end else if (m_valid[0] && rdy) begin
        m_valid[0] = 1'b0;
      end
      if (fire[1]) begin
        q3.push_back(g[1]);
        m_valid[1] = 1'b1;
        m_last[1]  = g[1];
      end else if (m_valid[1] && rdy) begin
        m_valid[1] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("valid4", {31'd0, ov4}, {31'd0, m_valid[0]});
    chk("valid3", {31'd0, ov3}, {31'd0, m_valid[1]});
    if (r) begin
      chk("rst_idx4", {30'd0, idx4}, 32'd0);
      chk("rst_onehot4", {28'd0, oh4}, 32'd0);
      chk("rst_idx3", {30'd0, idx3}, 32'd0);
    end
    if (ov3) begin
      checks++;
      assert (idx3 !== 2'd3) else begin
        errors++;
        $error("FAIL idx3_range observed=%0d expected=<3", idx3);
      end
    end
  endtask

  initial begin
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    m_last[0]  = 3;
    m_last[1]  = 2;

    // Reset with all requests high: no pops.
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    // Full rotation, then the first grant after reset must be port 0.
    #0;
    step(4'b1111, 1'b1, 1'b0);
    chk("first_idx_after_rst", {30'd0, idx4}, 32'd0);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b0);

    // Sparse wrap: set last to 1, then alternate 3,1,3.
    step(4'b1111, 1'b1, 1'b1);
    step(4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b1010, 1'b1, 1'b0);

    // Backpressure with two requestors.
    step(4'b0110, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0110, 1'b0, 1'b0);
    step(4'b0110, 1'b1, 1'b0);
    step(4'b0110, 1'b1, 1'b0);

    // Drain and idle, then a lone request on port 2.
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Mid-operation reset discards a held grant.
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b1);
    step(4'b0110, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Rotation with all requests: exercises the 3-port wrap.
    step(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 1'b0);

    // Random traffic with occasional backpressure and rare resets.
    for (int i = 0; i < 80; i++) begin
      logic [3:0] rv;
      logic       rdy;
      logic       r;
      rv  = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 29) == 0);
      step(rv, rdy, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
